// File: rtl/fc_mac_engine.sv
// Sequential fully-connected MAC: streams LANES activations per beat against a runtime-loadable
// weight memory for N_OUT neurons. Define FC_MAC_SAT_EN for saturating accumulation with sticky ovf.
module fc_mac_engine #(
    parameter int N_IN  = 108,
    parameter int N_OUT = 2,
    parameter int LANES = 3,
    parameter int IN_W  = 2,
    parameter int W_W   = 3,
    parameter int ACC_W = 12
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            start,
    input  logic                            in_valid,
    output logic                            in_ready,
    input  logic [LANES*IN_W-1:0]           in_data,
    input  logic                            w_we,
    input  logic [$clog2(N_OUT*N_IN)-1:0]   w_addr,
    input  logic [W_W-1:0]                  w_data,
    output logic                            out_valid,
    input  logic                            out_ready,
    output logic [N_OUT*ACC_W-1:0]          out_data,
    output logic [N_OUT-1:0]                ovf
);

    localparam int DEPTH  = N_OUT * N_IN;
    localparam int AW     = $clog2(DEPTH);
    localparam int BEATS  = N_IN / LANES;
    localparam int CNT_W  = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int PROD_W = IN_W + W_W + 1;
    localparam int SUM_W  = PROD_W + $clog2(LANES) + 1;

    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BEATS - 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_ACC  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]              state;
    logic [CNT_W-1:0]        cnt;
    logic signed [W_W-1:0]   wmem     [DEPTH];
    logic signed [ACC_W-1:0] acc      [N_OUT];
    logic signed [ACC_W-1:0] acc_next [N_OUT];
    logic signed [SUM_W-1:0] lane_sum [N_OUT];

    assign in_ready  = (state == S_ACC);
    assign out_valid = (state == S_DONE);

    for (genvar g = 0; g < N_OUT; g++) begin : g_out
        assign out_data[g*ACC_W +: ACC_W] = acc[g];
    end

    // Weight storage has no reset so loaded coefficients survive rst_n.
    always_ff @(posedge clk) begin
        if (w_we && state == S_IDLE && int'(w_addr) < DEPTH)
            wmem[w_addr] <= w_data;
    end

    always_comb begin
        logic [AW-1:0]            idx;
        logic signed [PROD_W-1:0] act;
        logic signed [PROD_W-1:0] wt;
        idx = '0;
        act = '0;
        wt  = '0;
        for (int o = 0; o < N_OUT; o++) begin
            lane_sum[o] = '0;
            for (int l = 0; l < LANES; l++) begin
                idx = AW'(o*N_IN + int'(cnt)*LANES + l);
                act = PROD_W'({1'b0, in_data[l*IN_W +: IN_W]});
                wt  = PROD_W'(wmem[idx]);
                lane_sum[o] = lane_sum[o] + SUM_W'(act * wt);
            end
        end
    end

`ifdef FC_MAC_SAT_EN
    localparam int EXT_W = ((ACC_W > SUM_W) ? ACC_W : SUM_W) + 1;
    localparam logic signed [EXT_W-1:0] SAT_MAX = {{(EXT_W-ACC_W+1){1'b0}}, {(ACC_W-1){1'b1}}};
    localparam logic signed [EXT_W-1:0] SAT_MIN = {{(EXT_W-ACC_W+1){1'b1}}, {(ACC_W-1){1'b0}}};

    logic [N_OUT-1:0] clamp;
    logic [N_OUT-1:0] ovf_r;

    // Sum is formed one bit wider than either operand so the clamp sees the true value.
    always_comb begin
        logic signed [EXT_W-1:0] ext;
        ext = '0;
        for (int o = 0; o < N_OUT; o++) begin
            ext      = EXT_W'(acc[o]) + EXT_W'(lane_sum[o]);
            clamp[o] = 1'b0;
            if (ext > SAT_MAX) begin
                acc_next[o] = ACC_W'(SAT_MAX);
                clamp[o]    = 1'b1;
            end else if (ext < SAT_MIN) begin
                acc_next[o] = ACC_W'(SAT_MIN);
                clamp[o]    = 1'b1;
            end else begin
                acc_next[o] = ACC_W'(ext);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            ovf_r <= '0;
        else if (state == S_IDLE && start)
            ovf_r <= '0;
        else if (state == S_ACC && in_valid)
            ovf_r <= ovf_r | clamp;
    end

    assign ovf = ovf_r;
`else
    always_comb begin
        for (int o = 0; o < N_OUT; o++)
            acc_next[o] = acc[o] + ACC_W'(lane_sum[o]);
    end

    assign ovf = '0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
            cnt   <= '0;
            for (int o = 0; o < N_OUT; o++)
                acc[o] <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        state <= S_ACC;
                        cnt   <= '0;
                        for (int o = 0; o < N_OUT; o++)
                            acc[o] <= '0;
                    end
                end
                S_ACC: begin
                    if (in_valid) begin
                        for (int o = 0; o < N_OUT; o++)
                            acc[o] <= acc_next[o];
                        if (cnt == LAST_BEAT)
                            state <= S_DONE;
                        else
                            cnt <= cnt + CNT_W'(1);
                    end
                end
                S_DONE: begin
                    if (out_ready)
                        state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: doc/fc_mac_engine.md
# fc_mac_engine

Parametrised, sequential fully-connected MAC engine for the BNN VAD datapath. It streams quantised activations in LANES elements per beat and accumulates signed dot products against an on-chip weight memory for N_OUT output neurons in parallel. When the last beat arrives, it presents all N_OUT accumulators with a valid/ready handshake. It replaces the fixed 108-input, 2-output, 3-lane FC MAC and adds runtime-loadable weights, flow control, configurable widths and optional saturation.

## Interface
- N_IN, 108, input vector length; must be a multiple of LANES
- N_OUT, 2, output neurons computed in parallel
- LANES, 3, input elements consumed per beat
- IN_W, 2, activation width, unsigned
- W_W, 3, weight width, signed two's complement
- ACC_W, 12, accumulator and output width, signed
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- start  in  1  begin a new vector; honoured only in IDLE
- in_valid  in  1  in_data beat valid
- in_ready  out  1  engine accepts a beat; high only in ACC
- in_data  in  LANES*IN_W  lane l at bits [l*IN_W +: IN_W]; lane l is element beat*LANES+l
- w_we  in  1  weight write strobe
- w_addr  in  $clog2(N_OUT*N_IN)  weight index o*N_IN+i
- w_data  in  W_W  weight value
- out_valid  out  1  results available
- out_ready  in  1  consumer accepts results
- out_data  out  N_OUT*ACC_W  neuron o at bits [o*ACC_W +: ACC_W]
- ovf  out  N_OUT  per-neuron sticky saturation flag

## Operation
- FSM states:
  - IDLE → ACC on start; in the same edge, clear all accumulators, ovf and the beat counter.
  - ACC → DONE on the accepted beat where the counter equals N_IN/LANES-1.
  - DONE → IDLE on out_valid && out_ready.
- A beat is accepted when in_valid && in_ready. Each accepted beat increments the counter.
- Per accepted beat, every neuron o updates: acc[o] += Σ_l zext(in_data[l]) * W[o*N_IN + beat*LANES + l].
  - Products are signed with width IN_W+W_W+1.
  - The lane sum is computed at full width, then added to acc.
- Default arithmetic is two's-complement wrap at ACC_W.
- Weight memory has N_OUT*N_IN entries. A write takes effect when w_we is high in IDLE. w_we in ACC or DONE is ignored. Out-of-range w_addr is ignored.
- The weight memory is not cleared by reset; contents survive rst_n.
- out_data reflects the accumulators continuously. It is stable throughout DONE.
- start outside IDLE is ignored.

## Timing
- Reset values: state IDLE, in_ready 0, out_valid 0, out_data 0, ovf 0, counter 0.
- When start is sampled at edge t, in_ready is 1 from t+1.
- A beat accepted at edge t updates acc at t+1.
- When the last beat is accepted at edge t, at t+1:
  - out_valid is 1;
  - in_ready is 0;
  - out_data is final.
- With continuous in_valid, out_valid rises N_IN/LANES+1 cycles after the start edge (37 at default parameters).
- When the output handshake occurs at edge t, out_valid is 0 from t+1. The earliest new start is at t+1.
- in_valid low stalls ACC indefinitely; the counter and accumulators hold.
- Asserting rst_n mid-ACC or mid-DONE returns to IDLE immediately. The partial result is discarded.

## Configuration
- FC_MAC_SAT_EN defined:
  - Each accumulate clamps to [-2^(ACC_W-1), 2^(ACC_W-1)-1].
  - ovf[o] sets on any clamp and stays set until the next start.
- FC_MAC_SAT_EN undefined:
  - Accumulation wraps.
  - ovf is tied to 0.

## Test plan
- Defaults, all weights +1, in_data lanes all 3, continuous in_valid → out_valid at start+37, out_data = {324, 324}, ovf = 0.
- Weights alternate +1/-1 by index, inputs all 2 → both outputs 0. Neuron 1 weights all -2, inputs all 1 → out[1] = -216.
- Same as scenario 1, but in_valid high every other cycle → identical result, out_valid at start+72, counter held during gaps.
- ACC_W=8, weights +3, inputs 3 (true sum 972):
  - without macro → out = -52 (972 mod 256 as signed), ovf 0;
  - with FC_MAC_SAT_EN → out = 127, ovf = 2'b11.
- In DONE, hold out_ready low for 10 cycles while pulsing start and w_we → out_valid and out_data stable, no state change, weights unchanged. Raise out_ready → IDLE next cycle.
- Assert rst_n low at beat 20 → outputs reset values. Restart without reloading weights → scenario 1 result reproduced.
